mem_port_arbiter: RTL and testbench

//  Shares one external memory port between instruction fetch (IF) and the
//  MEM-stage data access of the five-stage core (unified-memory build).

---
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and MEM-stage data
// access: one transaction in flight, one-cycle ack pulse, sticky timeout flag.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int PRIORITY = 0,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  // A zero-width counter is illegal, so MAX_WAIT=0 still gets one bit.
  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LAST_WAIT = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_next;
  logic          grant_dm;
  logic          last_grant_dm;
  logic [CW-1:0] wait_cnt;
  logic          start, pick_dm, complete, abort;

  always_comb begin
    state_next = state;
    start      = 1'b0;
    pick_dm    = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          start      = 1'b1;
          state_next = BUSY;
          if (if_req && dm_req)
            pick_dm = (PRIORITY == 0) ? 1'b1 : !last_grant_dm;
          else
            pick_dm = dm_req;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          complete   = 1'b1;
          state_next = DONE;
        end else if ((MAX_WAIT != 0) && (wait_cnt == LAST_WAIT)) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction registers; the memory-side fields stay frozen for the whole BUSY phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant_dm      <= 1'b0;
      last_grant_dm <= 1'b0;
      wait_cnt      <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      if_rdata      <= '0;
      dm_rdata      <= '0;
      timeout_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        grant_dm      <= pick_dm;
        last_grant_dm <= pick_dm;
        wait_cnt      <= '0;
        mem_req       <= 1'b1;
        mem_we        <= pick_dm & dm_we;
        mem_addr      <= pick_dm ? dm_addr : if_addr;
        mem_wdata     <= pick_dm ? dm_wdata : '0;
      end
      if (complete) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (!mem_we) begin
          if (grant_dm) dm_rdata <= mem_rdata;
          else          if_rdata <= mem_rdata;
        end
      end else if (abort) begin
        mem_req     <= 1'b0;
        mem_we      <= 1'b0;
        timeout_err <= 1'b1;
        if (grant_dm) dm_rdata <= '0;
        else          if_rdata <= '0;
      end else if ((state == BUSY) && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  assign if_ack = (state == DONE) && !grant_dm;
  assign dm_ack = (state == DONE) && grant_dm;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: dut0 is fixed priority with a short
// timeout, dut1 is round-robin; a behavioural memory answers both.
module tb_mem_port_arbiter;

  typedef struct {
    int          dut;
    bit          is_dm;
    logic [31:0] rdata;
  } sb_t;

  typedef struct {
    int          dut;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
    bit          stable;
  } txn_t;

  logic             clk;
  logic [1:0]       rst, if_req, if_ack, dm_req, dm_we, dm_ack;
  logic [1:0]       mem_req, mem_we, mem_ready, busy, timeout_err;
  logic [1:0][31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;

  int    assertions = 0;
  int    failures   = 0;
  int    ready_delay[2];
  string ack_log[2];
  sb_t   sb[$];
  txn_t  txn_log[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIORITY(0), .MAX_WAIT(4)) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ack(if_ack[0]),
    .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
    .dm_rdata(dm_rdata[0]), .dm_ack(dm_ack[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
    .busy(busy[0]), .timeout_err(timeout_err[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIORITY(1), .MAX_WAIT(15)) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ack(if_ack[1]),
    .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
    .dm_rdata(dm_rdata[1]), .dm_ack(dm_ack[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
    .busy(busy[1]), .timeout_err(timeout_err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0050_0093 : {a[15:0], 16'hC0DE};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic scoreCheck(input int d, input bit is_dm, input logic [31:0] actual);
    int    idx;
    string tag;
    idx = -1;
    tag = is_dm ? "D" : "I";
    ack_log[d] = {ack_log[d], tag};
    for (int i = 0; i < sb.size(); i++) begin
      if (idx < 0 && sb[i].dut == d && sb[i].is_dm == is_dm) idx = i;
    end
    if (idx < 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL unexpected_ack dut%0d %s: actual ack, required none", d, tag);
    end else begin
      checkOutput(is_dm ? "dm_rdata" : "if_rdata", actual, sb[idx].rdata);
      sb.delete(idx);
    end
  endtask

  // Memory model: asserts mem_ready after ready_delay low BUSY cycles, logs each transaction.
  initial begin
    int          cnt[2];
    logic [31:0] a0[2], w0[2];
    logic        we0[2];
    bit          stable[2];
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0; a0[d] = '0; w0[d] = '0; we0[d] = 1'b0; stable[d] = 1'b1;
    end
    mem_ready = '0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (mem_req[d]) begin
          if (cnt[d] == 0) begin
            a0[d] = mem_addr[d]; we0[d] = mem_we[d]; w0[d] = mem_wdata[d]; stable[d] = 1'b1;
          end else if (mem_addr[d] !== a0[d] || mem_we[d] !== we0[d] || mem_wdata[d] !== w0[d]) begin
            stable[d] = 1'b0;
          end
          mem_ready[d] = (cnt[d] >= ready_delay[d]);
          mem_rdata[d] = mem_ready[d] ? memData(mem_addr[d]) : 32'hBADB_AD00;
          cnt[d]++;
        end else begin
          if (cnt[d] != 0) txn_log.push_back('{d, we0[d], a0[d], w0[d], cnt[d], stable[d]});
          cnt[d] = 0;
          mem_ready[d] = 1'b0;
          mem_rdata[d] = 32'hBADB_AD00;
        end
      end
    end
  end

  // Monitor: every ack pops the matching scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (if_ack[d] || dm_ack[d]) begin
          checkOutput("single_ack", 32'(if_ack[d] & dm_ack[d]), 32'd0);
          if (if_ack[d]) scoreCheck(d, 1'b0, if_rdata[d]);
          if (dm_ack[d]) scoreCheck(d, 1'b1, dm_rdata[d]);
        end
      end
    end
  end

  task automatic applyStimulus(input int d, input bit is_dm, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata, output int lat);
    @(negedge clk);
    sb.push_back('{d, is_dm, exp_rdata});
    if (is_dm) begin
      dm_req[d] = 1'b1; dm_we[d] = we; dm_addr[d] = addr; dm_wdata[d] = wdata;
    end else begin
      if_req[d] = 1'b1; if_addr[d] = addr;
    end
    lat = 0;
    while (!(is_dm ? dm_ack[d] : if_ack[d]) && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 60) begin
      assertions++;
      failures++;
      $display("[TB] FAIL ack_wait dut%0d: actual no ack in 60 cycles, required ack", d);
    end
    @(posedge clk);
    #1;
    if (is_dm) dm_req[d] = 1'b0;
    else       if_req[d] = 1'b0;
  endtask

  task automatic checkTxn(input int d, input int exp_len, input logic exp_we,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
    int idx;
    idx = -1;
    for (int i = 0; i < txn_log.size(); i++) begin
      if (idx < 0 && txn_log[i].dut == d) idx = i;
    end
    if (idx < 0) begin
      assertions++;
      failures++;
      $display("[TB] FAIL txn_missing dut%0d: actual none, required one transaction", d);
    end else begin
      checkOutput("txn_len",    32'(txn_log[idx].len), 32'(exp_len));
      checkOutput("txn_we",     32'(txn_log[idx].we), 32'(exp_we));
      checkOutput("txn_addr",   txn_log[idx].addr, exp_addr);
      checkOutput("txn_wdata",  txn_log[idx].wdata, exp_wdata);
      checkOutput("txn_stable", 32'(txn_log[idx].stable), 32'd1);
      txn_log.delete(idx);
    end
  endtask

  function automatic int countTxn(input int d);
    int n;
    n = 0;
    foreach (txn_log[i]) if (txn_log[i].dut == d) n++;
    return n;
  endfunction

  task automatic clearTxn(input int d);
    for (int i = txn_log.size() - 1; i >= 0; i--) if (txn_log[i].dut == d) txn_log.delete(i);
  endtask

  initial begin
    int lat;
    rst = 2'b11;
    if_req = '0; dm_req = '0; dm_we = '0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    ready_delay[0] = 0; ready_delay[1] = 0;
    ack_log[0] = ""; ack_log[1] = "";
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",     32'(busy), 32'd0);
    checkOutput("rst_mem_req",  32'(mem_req), 32'd0);
    checkOutput("rst_timeout",  32'(timeout_err), 32'd0);
    checkOutput("rst_acks",     32'({if_ack, dm_ack}), 32'd0);
    checkOutput("rst_if_rdata", if_rdata[0], 32'd0);
    checkOutput("rst_dm_rdata", dm_rdata[0], 32'd0);
    rst = 2'b00;

    // Single fetch with an immediately ready memory.
    applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0050_0093, lat);
    checkOutput("if_latency", 32'(lat), 32'd2);
    checkTxn(0, 1, 1'b0, 32'h0, 32'h0);
    checkOutput("if_dm_rdata_kept", dm_rdata[0], 32'd0);

    // Load then store; the store must not disturb dm_rdata.
    applyStimulus(0, 1'b1, 1'b0, 32'h44, 32'h0, 32'h0044_C0DE, lat);
    clearTxn(0);
    ready_delay[0] = 3;
    applyStimulus(0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0044_C0DE, lat);
    checkOutput("wr_latency", 32'(lat), 32'd5);
    checkTxn(0, 4, 1'b1, 32'h40, 32'hDEAD_BEEF);

    // Fixed-priority tie: data, fetch, then the data re-request.
    ready_delay[0] = 0;
    ack_log[0] = "";
    fork
      begin
        applyStimulus(0, 1'b1, 1'b0, 32'h48, 32'h0, 32'h0048_C0DE, lat);
        @(posedge clk);
        applyStimulus(0, 1'b1, 1'b0, 32'h4C, 32'h0, 32'h004C_C0DE, lat);
      end
      begin
        int lat_if;
        applyStimulus(0, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0104_C0DE, lat_if);
      end
    join
    assertions++;
    if (ack_log[0] != "DID") begin
      failures++;
      $display("[TB] FAIL fixed_order: actual %s, required DID", ack_log[0]);
    end

    // Hung memory: abort after four BUSY cycles, error stays sticky.
    clearTxn(0);
    ready_delay[0] = 1000;
    applyStimulus(0, 1'b0, 1'b0, 32'h108, 32'h0, 32'h0, lat);
    checkOutput("to_latency", 32'(lat), 32'd5);
    checkTxn(0, 4, 1'b0, 32'h108, 32'h0);
    checkOutput("to_err_set", 32'(timeout_err[0]), 32'd1);
    ready_delay[0] = 0;
    applyStimulus(0, 1'b1, 1'b0, 32'h50, 32'h0, 32'h0050_C0DE, lat);
    checkOutput("to_err_sticky", 32'(timeout_err[0]), 32'd1);

    // Requester holds req through the DONE edge: still exactly one transaction.
    clearTxn(0);
    applyStimulus(0, 1'b0, 1'b0, 32'h10C, 32'h0, 32'h010C_C0DE, lat);
    repeat (4) @(negedge clk);
    checkOutput("single_txn", 32'(countTxn(0)), 32'd1);
    checkOutput("idle_after", 32'(busy[0]), 32'd0);

    // Reset while BUSY abandons the transaction without an ack.
    ready_delay[0] = 1000;
    @(negedge clk);
    dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h60;
    @(negedge clk);
    checkOutput("pre_rst_busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    rst[0] = 1'b1;
    dm_req[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    checkOutput("rst_busy_mem_req", 32'(mem_req[0]), 32'd0);
    checkOutput("rst_busy_busy",    32'(busy[0]), 32'd0);
    checkOutput("rst_busy_timeout", 32'(timeout_err[0]), 32'd0);
    checkOutput("rst_busy_dm_rdata", dm_rdata[0], 32'd0);
    repeat (3) @(negedge clk);
    clearTxn(0);
    ready_delay[0] = 0;
    applyStimulus(0, 1'b1, 1'b0, 32'h64, 32'h0, 32'h0064_C0DE, lat);
    checkOutput("post_rst_latency", 32'(lat), 32'd2);

    // Round-robin ties on dut1, both requesters re-requesting back-to-back.
    ack_log[1] = "";
    fork
      begin
        int lat_d;
        applyStimulus(1, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0080_C0DE, lat_d);
        applyStimulus(1, 1'b1, 1'b0, 32'h84, 32'h0, 32'h0084_C0DE, lat_d);
      end
      begin
        int lat_i;
        applyStimulus(1, 1'b0, 1'b0, 32'h180, 32'h0, 32'h0180_C0DE, lat_i);
        applyStimulus(1, 1'b0, 1'b0, 32'h184, 32'h0, 32'h0184_C0DE, lat_i);
      end
    join
    assertions++;
    if (ack_log[1] != "DIDI") begin
      failures++;
      $display("[TB] FAIL rr_order: actual %s, required DIDI", ack_log[1]);
    end

    repeat (4) @(negedge clk);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
